// File: rtl/seg7_pkg.sv
// Shared seven-segment pattern definitions, active-low {g,f,e,d,c,b,a}.
// The display driver uses the same constants, so the encoder and decoder stay in step.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-low segment pattern back to its BCD value.
// Anything that is neither a digit nor blank reports is_digit=0, is_blank=0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] value,
  output logic       is_digit,
  output logic       is_blank
);

  always_comb begin
    value    = 4'd0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus: filters
// scan ghosting with a stability counter and rebuilds the BCD value per digit.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        a2g,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_valid,
  output logic              bad_pattern,
  output logic              multi_an,
  output logic              frame_done
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

  // Stage p0: input register; everything downstream sees only these copies
  logic [NDIG-1:0] an_p0;
  seg_t            seg_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      an_p0  <= '1;
      seg_p0 <= SEG_BLANK;
    end else begin
      an_p0  <= an;
      seg_p0 <= a2g;
    end
  end

  logic [3:0]       n_low;
  logic [IDX_W-1:0] idx_p0;
  logic             vld_p0;
  logic             multi_p0;

  always_comb begin
    n_low  = 4'd0;
    idx_p0 = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_p0[i]) begin
        n_low  = n_low + 4'd1;
        idx_p0 = IDX_W'(i);
      end
    end
    vld_p0   = (n_low == 4'd1);
    multi_p0 = (n_low > 4'd1);
  end

  logic [3:0] dec_value;
  logic       dec_is_digit;
  logic       dec_is_blank;

  seg7_pattern_decode u_decode (
    .seg      (seg_p0),
    .value    (dec_value),
    .is_digit (dec_is_digit),
    .is_blank (dec_is_blank)
  );

  // Stage p1: stability filter, capture registers and frame tracking
  logic [IDX_W-1:0] idx_p1;
  seg_t             seg_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             captured_p1;
  logic             multi_p1;
  logic [NDIG-1:0]  seen_p1;

  logic             same;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             capture;
  logic             captured_nxt;
  logic [NDIG-1:0]  seen_set;

  always_comb begin
    // cnt_p1 == 0 means the previous sample was idle/multi, so nothing to match
    same     = vld_p0 && (cnt_p1 != '0) && (idx_p0 == idx_p1) && (seg_p0 == seg_p1);
    cnt_nxt  = '0;
    if (vld_p0) begin
      if (!same)                  cnt_nxt = CNT_W'(1);
      else if (cnt_p1 < STABLE_C) cnt_nxt = cnt_p1 + CNT_W'(1);
      else                        cnt_nxt = cnt_p1;
    end
    armed        = same && captured_p1;
    capture      = vld_p0 && (cnt_nxt == STABLE_C) && !armed;
    captured_nxt = vld_p0 && (armed || capture);
    seen_set     = seen_p1 | (NDIG'(1) << idx_p0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p1      <= '0;
      seg_p1      <= SEG_BLANK;
      cnt_p1      <= '0;
      captured_p1 <= 1'b0;
      multi_p1    <= 1'b0;
      seen_p1     <= '0;
      digits      <= '0;
      digit_valid <= '0;
      bad_pattern <= 1'b0;
      multi_an    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      idx_p1      <= idx_p0;
      seg_p1      <= seg_p0;
      cnt_p1      <= cnt_nxt;
      captured_p1 <= captured_nxt;
      multi_p1    <= multi_p0;
      multi_an    <= multi_p0 && !multi_p1;
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
      if (capture) begin
        if (dec_is_digit) begin
          digits[int'(idx_p0)*4 +: 4] <= dec_value;
          digit_valid[idx_p0]         <= 1'b1;
        end else begin
          digit_valid[idx_p0]         <= 1'b0;
        end
        bad_pattern <= !dec_is_digit && !dec_is_blank;
        if (&seen_set) begin
          frame_done <= 1'b1;
          seen_p1    <= '0;
        end else begin
          seen_p1    <= seen_set;
        end
      end
    end
  end

endmodule
